// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - divide/modulo controller for shared signed/unsigned divider IPs; optional result cache via DIV_RESULT_CACHE_EN
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_quot,
  output logic [31:0] rsp_rem,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        sdiv_in_valid,
  input  logic        sdiv_in_ready,
  input  logic        sdiv_out_valid,
  input  logic [63:0] sdiv_out_data,
  output logic        udiv_in_valid,
  input  logic        udiv_in_ready,
  input  logic        udiv_out_valid,
  input  logic [63:0] udiv_out_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        sel_signed;
  logic        sel_in_ready;
  logic        sel_out_valid;
  logic [63:0] sel_out_data;
  logic        accept;
  logic        capture;
  logic        cache_hit;

  // The select register steers every IP-facing signal; the other IP is ignored entirely.
  assign sel_in_ready  = sel_signed ? sdiv_in_ready  : udiv_in_ready;
  assign sel_out_valid = sel_signed ? sdiv_out_valid : udiv_out_valid;
  assign sel_out_data  = sel_signed ? sdiv_out_data  : udiv_out_data;

`ifdef DIV_RESULT_CACHE_EN
  logic        cache_vld;
  logic        cache_signed;
  logic [31:0] cache_src1;
  logic [31:0] cache_src2;
  logic [31:0] cache_quot;
  logic [31:0] cache_rem;

  assign cache_hit = cache_vld && (cache_signed == req_signed) &&
                     (cache_src1 == req_src1) && (cache_src2 == req_src2);

  // Single-entry result cache, refreshed on every delivered result; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld    <= 1'b0;
      cache_signed <= 1'b0;
      cache_src1   <= '0;
      cache_src2   <= '0;
      cache_quot   <= '0;
      cache_rem    <= '0;
    end else if (capture) begin
      cache_vld    <= 1'b1;
      cache_signed <= sel_signed;
      cache_src1   <= div_dividend;
      cache_src2   <= div_divisor;
      cache_quot   <= sel_out_data[63:32];
      cache_rem    <= sel_out_data[31:0];
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; everything is held low while rst is asserted.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    sdiv_in_valid = 1'b0;
    udiv_in_valid = 1'b0;
    accept        = 1'b0;
    capture       = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          req_ready = 1'b1;
          if (req_valid && !flush) begin
            accept    = 1'b1;
            state_nxt = cache_hit ? S_DONE : S_SEND;
          end
        end
        S_SEND: begin
          sdiv_in_valid = sel_signed  && !flush;
          udiv_in_valid = !sel_signed && !flush;
          if (flush) begin
            state_nxt = S_IDLE;
          end else if (sel_in_ready) begin
            state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (sel_out_valid) begin
            if (flush) begin
              state_nxt = S_IDLE;
            end else begin
              capture   = 1'b1;
              state_nxt = S_DONE;
            end
          end else if (flush) begin
            state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (sel_out_valid) begin
            state_nxt = S_IDLE;
          end
        end
        S_DONE: begin
          rsp_valid = !flush;
          if (flush || rsp_ready) begin
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Operand/select latch on accept and result capture from the selected IP.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_dividend <= '0;
      div_divisor  <= '0;
      sel_signed   <= 1'b0;
      rsp_quot     <= '0;
      rsp_rem      <= '0;
    end else begin
      if (accept) begin
        div_dividend <= req_src1;
        div_divisor  <= req_src2;
        sel_signed   <= req_signed;
      end
`ifdef DIV_RESULT_CACHE_EN
      if (accept && cache_hit) begin
        rsp_quot <= cache_quot;
        rsp_rem  <= cache_rem;
      end
`endif
      if (capture) begin
        rsp_quot <= sel_out_data[63:32];
        rsp_rem  <= sel_out_data[31:0];
      end
    end
  end

endmodule
